alu_cmd_issuer: RTL and testbench
=================================

Name: alu_cmd_issuer

Overview:
Upstream command stage for the ALU. It accepts tagged operation commands over a valid/ready handshake and buffers them in a small FIFO. Commands are issued to the ALU one at a time on registered a/b/op_code lines. After a fixed ALU latency it captures result/carry_out and returns them, with the tag, on a valid/ready response channel. Responses come back in command order.

Parameters:
DEPTH, 4, command FIFO entries (power of two, 2..16)
ALU_LAT, 1, rising edges from alu_* load to the edge at which alu_result/alu_carry_out are sampled (1..8)
TAG_W, 4, command/response tag width

Ports:
clock  input  1  single clock for the block
reset_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  FIFO not full
cmd_a  input  8  operand A
cmd_b  input  8  operand B
cmd_op  input  4  opcode: 0 ADD, 1 SUB, 2 MUL, 3 DIV
cmd_tag  input  TAG_W  returned unchanged with the response
alu_a  output  8  registered operand A to ALU
alu_b  output  8  registered operand B to ALU
alu_op_code  output  4  registered opcode to ALU
alu_result  input  8  ALU result
alu_carry_out  input  1  ALU carry
rsp_valid  output  1  response held until accepted
rsp_ready  input  1  consumer accepts
rsp_result  output  8  captured result
rsp_carry  output  1  captured carry
rsp_tag  output  TAG_W  tag of the command
rsp_err  output  1  locally rejected command (0 unless macro enabled)

Behaviour:
- Reset (async assert, sync deassert by the system): FIFO empty, state IDLE, alu_a/alu_b/alu_op_code = 0, rsp_valid = 0, rsp_result = 0, rsp_carry = 0, rsp_tag = 0, rsp_err = 0.
- After reset, cmd_ready = 1.
- Push: occurs on cmd_valid && cmd_ready. cmd_ready = !full and is purely a function of occupancy; it stays low when full even if a pop happens in the same cycle.
- FSM states: IDLE, WAIT, RESP.
- IDLE with FIFO non-empty: pop the head entry, load alu_* from it, set a latency counter to ALU_LAT, latch the tag, then go to WAIT. With the FIFO empty, stay in IDLE; alu_* hold their last values.
- WAIT: the counter decrements each edge. On the edge where the counter equals 1, capture alu_result and alu_carry_out into rsp_result and rsp_carry, then go to RESP.
- RESP: rsp_valid = 1 and the rsp_* outputs are stable. On rsp_valid && rsp_ready, clear rsp_valid and go to IDLE. A new pop happens no earlier than the next edge.
- Latency: a push at edge E0 into an empty FIFO with the FSM in IDLE gives alu_* loaded at E1 and capture at E1+ALU_LAT. rsp_valid is high in the cycle after that edge.
- Throughput: one command per ALU_LAT+2 cycles with rsp_ready tied high.
- Capacity: one command in flight or in RESP, plus DEPTH entries in the FIFO.
- Data widths: all 8 bits; no local arithmetic; the ALU's 0xAC convention for DIV-by-0 and unknown opcodes passes through unchanged.
- Reset mid-operation: the in-flight command and all FIFO contents are discarded; no response is ever produced for them.
- FIFO pointers: wrap modulo DEPTH; full/empty are distinguished by an extra pointer bit.

Optional Feature:
ALU_PRECHECK_EN
- Defined: in IDLE, a head entry with cmd_op > 3, or with cmd_op = 3 and cmd_b = 0, is popped but not issued. alu_* remain unchanged. The response is formed at that same edge: rsp_result = 8'hAC, rsp_carry = 0, rsp_err = 1. The FSM goes directly to RESP, skipping WAIT.
- Undefined: every command is issued to the ALU, and rsp_err is tied 0.

Decomposition:
- Shared package alu_pkg holds:
  - opcode enum (ADD=0, SUB=1, MUL=2, DIV=3)
  - ALU_ERR_VAL = 8'hAC
  - issuer state enum
  - command struct {a, b, op, tag}
- One sub-module, alu_cmd_fifo: parameterised synchronous FIFO of the command struct with full/empty flags and the same asynchronous active-low reset.

Test Plan:
- Reset test: hold reset_n = 0 with cmd_valid = 1 -> cmd_ready stays 0, rsp_valid = 0, alu_a/alu_b/alu_op_code = 0. After release, cmd_ready = 1 the next cycle.
- Single ADD: a=200, b=100, tag=3 with ALU_LAT=1 -> rsp_result = 0x2C, rsp_carry = 1, rsp_tag = 3; rsp_valid rises after edge E2.
- Back-pressure: rsp_ready = 0, push 6 commands with tags 0..5 -> 5 accepted, cmd_ready low on the 6th. Raise rsp_ready -> responses arrive with tags 0..4 in order, then tag 5 is accepted.
- Arithmetic sweep: DIV 100/7 -> 14, carry 0; MUL 16*17 -> 0x10; SUB 5-9 -> 0xFC.
- DIV 50/0, macro defined: result 0xAC, rsp_err = 1, alu_op_code unchanged.
- DIV 50/0, macro undefined: issued to the ALU, result 0xAC, rsp_err = 0.
- Reset mid-WAIT: assert reset_n = 0 during WAIT -> rsp_valid never asserts for that tag, FIFO empty, and after release the next command behaves as in the single-ADD test.

Source files
------------

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared types for the ALU command issuer and its command FIFO.
//   alu_op_e        : ALU opcodes (ADD=0, SUB=1, MUL=2, DIV=3)
//   ALU_ERR_VAL     : value the ALU returns for DIV-by-0 and unknown opcodes
//   issuer_state_e  : issuer FSM states
//   alu_cmd_t       : one buffered command {a, b, op, tag}
//   cmd_rejected()  : opcode/operand check used when ALU_PRECHECK_EN is defined
// The tag field is sized for the widest supported tag (CMD_TAG_MAX_W); the
// issuer zero-extends narrower tags into it and truncates on the way out.
// -----------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_MUL = 4'd2,
        OP_DIV = 4'd3
    } alu_op_e;

    localparam logic [7:0] ALU_ERR_VAL   = 8'hAC;
    localparam int         CMD_TAG_MAX_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } issuer_state_e;

    typedef struct packed {
        logic [7:0]               a;
        logic [7:0]               b;
        logic [3:0]               op;
        logic [CMD_TAG_MAX_W-1:0] tag;
    } alu_cmd_t;

    // A command the ALU would only answer with ALU_ERR_VAL.
    function automatic logic cmd_rejected(input alu_cmd_t c);
        return (c.op > OP_DIV) || ((c.op == OP_DIV) && (c.b == 8'd0));
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// -----------------------------------------------------------------------------
// alu_cmd_fifo
// Synchronous FIFO of alu_cmd_t with full/empty flags. Pointers carry one
// extra bit so full and empty are distinguishable when the indices match.
// Ports:
//   clock, reset_n : clock, asynchronous active-low reset (pointers only)
//   push, wr_data  : write request and entry (ignored when full)
//   pop            : read request (ignored when empty)
//   rd_data        : current head entry (valid while !empty)
//   full, empty    : occupancy flags
// -----------------------------------------------------------------------------
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clock,
    input  logic     reset_n,
    input  logic     push,
    input  alu_cmd_t wr_data,
    input  logic     pop,
    output alu_cmd_t rd_data,
    output logic     full,
    output logic     empty
);

    localparam int         AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    alu_cmd_t    mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/alu_cmd_issuer.sv
// -----------------------------------------------------------------------------
// alu_cmd_issuer
// Buffers tagged ALU commands in a FIFO, issues them one at a time on
// registered alu_a/alu_b/alu_op_code, samples alu_result/alu_carry_out
// ALU_LAT edges later and presents them with the tag on a valid/ready
// response channel. Responses leave in command order.
// Optional build macro: ALU_PRECHECK_EN -- commands with an unknown opcode or
// DIV by zero are answered locally (rsp_err=1, result ALU_ERR_VAL) without
// touching the ALU. Without it every command goes to the ALU, rsp_err = 0.
// Ports:
//   clock, reset_n                     : clock, async active-low reset
//   cmd_valid/cmd_ready                : command handshake
//   cmd_a, cmd_b, cmd_op, cmd_tag      : command payload
//   alu_a, alu_b, alu_op_code          : registered ALU operands/opcode
//   alu_result, alu_carry_out          : ALU outputs
//   rsp_valid/rsp_ready                : response handshake
//   rsp_result, rsp_carry, rsp_tag     : response payload
//   rsp_err                            : locally rejected command
// Parameters: DEPTH (2..16, power of two), ALU_LAT (1..8), TAG_W (<= 16).
// -----------------------------------------------------------------------------
module alu_cmd_issuer
    import alu_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int ALU_LAT = 1,
    parameter int TAG_W   = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [7:0]       cmd_a,
    input  logic [7:0]       cmd_b,
    input  logic [3:0]       cmd_op,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic [7:0]       alu_a,
    output logic [7:0]       alu_b,
    output logic [3:0]       alu_op_code,
    input  logic [7:0]       alu_result,
    input  logic             alu_carry_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [7:0]       rsp_result,
    output logic             rsp_carry,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_err
);

    localparam int CNT_W = 4;

    issuer_state_e    state;
    issuer_state_e    state_next;
    alu_cmd_t         wr_cmd;
    alu_cmd_t         head;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             issue;
    logic             capture;
    logic             ready_en;
    logic [CNT_W-1:0] cnt;
    logic [TAG_W-1:0] tag_r;
    logic             unused_tag_bits;
`ifdef ALU_PRECHECK_EN
    logic             reject;
`endif

    // ready_en holds cmd_ready low while reset is asserted and releases it on
    // the first edge after reset, independent of FIFO occupancy.
    assign cmd_ready = ready_en && !full;
    assign push      = cmd_valid && cmd_ready;
    assign wr_cmd    = '{a: cmd_a, b: cmd_b, op: cmd_op, tag: CMD_TAG_MAX_W'(cmd_tag)};

    // Tag bits above TAG_W are always zero; fold them into a sink.
    assign unused_tag_bits = ^head.tag;

    alu_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (push),
        .wr_data (wr_cmd),
        .pop     (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            ready_en <= 1'b0;
        end else begin
            state    <= state_next;
            ready_en <= 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        issue      = 1'b0;
        capture    = 1'b0;
`ifdef ALU_PRECHECK_EN
        reject     = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (!empty) begin
                    pop = 1'b1;
`ifdef ALU_PRECHECK_EN
                    if (cmd_rejected(head)) begin
                        reject     = 1'b1;
                        state_next = ST_RESP;
                    end else begin
                        issue      = 1'b1;
                        state_next = ST_WAIT;
                    end
`else
                    issue      = 1'b1;
                    state_next = ST_WAIT;
`endif
                end
            end
            ST_WAIT: begin
                if (cnt == CNT_W'(1)) begin
                    capture    = 1'b1;
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            alu_a       <= '0;
            alu_b       <= '0;
            alu_op_code <= '0;
            cnt         <= '0;
            tag_r       <= '0;
            rsp_valid   <= 1'b0;
            rsp_result  <= '0;
            rsp_carry   <= 1'b0;
            rsp_tag     <= '0;
        end else begin
            if (issue) begin
                alu_a       <= head.a;
                alu_b       <= head.b;
                alu_op_code <= head.op;
                cnt         <= CNT_W'(ALU_LAT);
                tag_r       <= head.tag[TAG_W-1:0];
            end else if (state == ST_WAIT) begin
                cnt <= cnt - CNT_W'(1);
            end

            if (capture) begin
                rsp_valid  <= 1'b1;
                rsp_result <= alu_result;
                rsp_carry  <= alu_carry_out;
                rsp_tag    <= tag_r;
`ifdef ALU_PRECHECK_EN
            end else if (reject) begin
                rsp_valid  <= 1'b1;
                rsp_result <= ALU_ERR_VAL;
                rsp_carry  <= 1'b0;
                rsp_tag    <= head.tag[TAG_W-1:0];
`endif
            end else if (rsp_valid && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

`ifdef ALU_PRECHECK_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)     rsp_err <= 1'b0;
        else if (reject)  rsp_err <= 1'b1;
        else if (capture) rsp_err <= 1'b0;
    end
`else
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// -----------------------------------------------------------------------------
// tb_alu_cmd_issuer
// Self-checking bench for alu_cmd_issuer. A behavioural ALU drives
// alu_result/alu_carry_out from the registered alu_* lines; expected
// responses come from a command-level reference model and a FIFO-ordered
// scoreboard. Honors ALU_PRECHECK_EN when defined.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alu_cmd_issuer;

    localparam int DEPTH = 4;
    localparam int LAT   = 1;
    localparam int NRAND = 60;
`ifdef ALU_PRECHECK_EN
    localparam bit PRECHECK = 1'b1;
`else
    localparam bit PRECHECK = 1'b0;
`endif

    typedef struct {
        logic [7:0] r;
        logic       c;
        logic [3:0] t;
        logic       e;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_a;
    logic [7:0] cmd_b;
    logic [3:0] cmd_op;
    logic [3:0] cmd_tag;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [3:0] alu_op_code;
    logic [7:0] alu_result;
    logic       alu_carry_out;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_result;
    logic       rsp_carry;
    logic [3:0] rsp_tag;
    logic       rsp_err;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    alu_cmd_issuer #(.DEPTH(DEPTH), .ALU_LAT(LAT), .TAG_W(4)) dut (
        .clock(clock), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_tag(cmd_tag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op_code(alu_op_code),
        .alu_result(alu_result), .alu_carry_out(alu_carry_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_carry(rsp_carry),
        .rsp_tag(rsp_tag), .rsp_err(rsp_err)
    );

    // Behavioural ALU: {carry, result}. Carry = ADD overflow, SUB borrow,
    // MUL overflow past 8 bits. DIV-by-0 and unknown opcodes give 0xAC.
    function automatic logic [8:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] op);
        logic [15:0] p;
        p = 16'(a) * 16'(b);
        case (op)
            4'd0:    return 9'(a) + 9'(b);
            4'd1:    return {a < b, 8'(a - b)};
            4'd2:    return {|p[15:8], p[7:0]};
            4'd3:    return (b == 8'd0) ? {1'b0, 8'hAC} : {1'b0, 8'(a / b)};
            default: return {1'b0, 8'hAC};
        endcase
    endfunction

    always_comb begin
        {alu_carry_out, alu_result} = alu_fn(alu_a, alu_b, alu_op_code);
    end

    // Reference: the response a command must produce.
    function automatic exp_t ref_rsp(input logic [7:0] a, input logic [7:0] b,
                                     input logic [3:0] op, input logic [3:0] tag);
        exp_t       e;
        logic [8:0] v;
        e.t = tag;
        e.e = 1'b0;
        if (PRECHECK && (op > 4'd3 || (op == 4'd3 && b == 8'd0))) begin
            e.r = 8'hAC;
            e.c = 1'b0;
            e.e = 1'b1;
        end else begin
            v   = alu_fn(a, b, op);
            e.r = v[7:0];
            e.c = v[8];
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_cmd(input logic [7:0] a, input logic [7:0] b,
                            input logic [3:0] op, input logic [3:0] tag);
        int n = 0;
        cmd_a = a; cmd_b = b; cmd_op = op; cmd_tag = tag; cmd_valid = 1'b1;
        while (!cmd_ready && n < 50) begin tick(); n++; end
        n_cmp++;
        if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL cmd_timeout: cmd_ready=%0b after %0d cycles, required 1", cmd_ready, n); end
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic get_rsp(output logic [7:0] r, output logic c, output logic [3:0] t, output logic e);
        int n = 0;
        rsp_ready = 1'b1;
        while (!rsp_valid && n < 50) begin tick(); n++; end
        n_cmp++;
        if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL rsp_timeout: rsp_valid=%0b after %0d cycles, required 1", rsp_valid, n); end
        r = rsp_result; c = rsp_carry; t = rsp_tag; e = rsp_err;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; cmd_valid = 1'b1; cmd_a = 8'h55; cmd_b = 8'h66; cmd_op = 4'd0; cmd_tag = 4'd1;
        rsp_ready = 1'b0;
        repeat (3) tick();
        n_cmp++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL rst_cmd_ready: got %0b required 0", cmd_ready); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_rsp_valid: got %0b required 0", rsp_valid); end
        n_cmp++; if ({alu_a, alu_b, alu_op_code} !== 20'h0) begin n_err++; $display("FAIL rst_alu: got %0h/%0h/%0h required 0", alu_a, alu_b, alu_op_code); end
        n_cmp++; if ({rsp_result, rsp_carry, rsp_tag, rsp_err} !== 14'h0) begin n_err++; $display("FAIL rst_rsp: got %0h/%0b/%0h/%0b required 0", rsp_result, rsp_carry, rsp_tag, rsp_err); end
        cmd_valid = 1'b0;
        reset_n   = 1'b1;
        tick();
        n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_ready: got %0b required 1", cmd_ready); end
    endtask

    task automatic test_single_add();
        rsp_ready = 1'b0;
        cmd_a = 8'd200; cmd_b = 8'd100; cmd_op = 4'd0; cmd_tag = 4'd3; cmd_valid = 1'b1;
        n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL add_ready: got %0b required 1", cmd_ready); end
        tick();                           // E0: push
        cmd_valid = 1'b0;
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL add_valid_e0: got %0b required 0", rsp_valid); end
        tick();                           // E1: issue
        n_cmp++; if ({alu_a, alu_b, alu_op_code} !== {8'd200, 8'd100, 4'd0}) begin n_err++; $display("FAIL add_alu_load: got %0d/%0d/%0d required 200/100/0", alu_a, alu_b, alu_op_code); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL add_valid_e1: got %0b required 0", rsp_valid); end
        repeat (LAT) tick();              // E1+LAT: capture
        n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL add_valid_cap: got %0b required 1", rsp_valid); end
        n_cmp++; if ({rsp_result, rsp_carry, rsp_tag, rsp_err} !== {8'h2C, 1'b1, 4'd3, 1'b0}) begin n_err++; $display("FAIL add_rsp: got %0h/%0b/%0h/%0b required 2c/1/3/0", rsp_result, rsp_carry, rsp_tag, rsp_err); end
        tick();
        n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL add_hold: got %0b required 1", rsp_valid); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL add_drop: got %0b required 0", rsp_valid); end
    endtask

    task automatic test_back_pressure();
        exp_t q[$];
        exp_t e;
        int   got = 0;
        int   cyc = 0;
        bit   acc;
        rsp_ready = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            cmd_a = 8'($urandom); cmd_b = 8'($urandom); cmd_op = 4'($urandom_range(2));
            cmd_tag = 4'(i); cmd_valid = 1'b1;
            n_cmp++; if (cmd_ready !== (i < DEPTH + 1)) begin n_err++; $display("FAIL bp_ready_%0d: got %0b required %0b", i, cmd_ready, (i < DEPTH + 1)); end
            if (i < DEPTH + 1) begin
                q.push_back(ref_rsp(cmd_a, cmd_b, cmd_op, cmd_tag));
                tick();
            end
        end
        repeat (3) tick();
        n_cmp++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL bp_full_hold: got %0b required 0", cmd_ready); end
        n_cmp++; if ({rsp_valid, rsp_tag} !== {1'b1, 4'd0}) begin n_err++; $display("FAIL bp_rsp_held: got valid %0b tag %0d required 1/0", rsp_valid, rsp_tag); end
        rsp_ready = 1'b1;
        while (got < DEPTH + 2 && cyc < 200) begin
            acc = cmd_valid && cmd_ready;
            if (rsp_valid) begin
                n_cmp++;
                if (q.size() == 0) begin n_err++; $display("FAIL bp_extra_rsp: got tag %0d required none", rsp_tag); end
                else begin
                    e = q.pop_front();
                    if ({rsp_result, rsp_carry, rsp_tag, rsp_err} !== {e.r, e.c, e.t, e.e} || rsp_tag !== 4'(got)) begin
                        n_err++; $display("FAIL bp_rsp_%0d: got %0h/%0b/%0d/%0b required %0h/%0b/%0d/%0b", got, rsp_result, rsp_carry, rsp_tag, rsp_err, e.r, e.c, e.t, e.e);
                    end
                end
                got++;
            end
            if (acc) q.push_back(ref_rsp(cmd_a, cmd_b, cmd_op, cmd_tag));
            tick(); cyc++;
            if (acc) cmd_valid = 1'b0;
        end
        rsp_ready = 1'b0;
        n_cmp++; if (got != DEPTH + 2) begin n_err++; $display("FAIL bp_count: got %0d responses required %0d", got, DEPTH + 2); end
    endtask

    task automatic test_arith();
        logic [7:0] ta [3] = '{8'd100, 8'd16, 8'd5};
        logic [7:0] tb [3] = '{8'd7, 8'd17, 8'd9};
        logic [3:0] to [3] = '{4'd3, 4'd2, 4'd1};
        logic [7:0] tr [3] = '{8'd14, 8'h10, 8'hFC};
        logic       tc [3] = '{1'b0, 1'b1, 1'b1};
        logic [7:0] r;
        logic       c, e;
        logic [3:0] t;
        for (int i = 0; i < 3; i++) begin
            send_cmd(ta[i], tb[i], to[i], 4'(10 + i));
            get_rsp(r, c, t, e);
            n_cmp++; if ({r, c, t, e} !== {tr[i], tc[i], 4'(10 + i), 1'b0}) begin n_err++; $display("FAIL arith_%0d: got %0h/%0b/%0d/%0b required %0h/%0b/%0d/0", i, r, c, t, e, tr[i], tc[i], 10 + i); end
        end
    endtask

    task automatic test_div_zero();
        logic [7:0] r;
        logic       c, e;
        logic [3:0] t;
        // Previous issued command was SUB (opcode 1).
        send_cmd(8'd50, 8'd0, 4'd3, 4'd9);
        get_rsp(r, c, t, e);
        n_cmp++; if ({r, c, t} !== {8'hAC, 1'b0, 4'd9}) begin n_err++; $display("FAIL div0_rsp: got %0h/%0b/%0d required ac/0/9", r, c, t); end
        n_cmp++; if (e !== PRECHECK) begin n_err++; $display("FAIL div0_err: got %0b required %0b", e, PRECHECK); end
        n_cmp++; if (alu_op_code !== (PRECHECK ? 4'd1 : 4'd3)) begin n_err++; $display("FAIL div0_alu_op: got %0d required %0d", alu_op_code, PRECHECK ? 1 : 3); end
    endtask

    task automatic test_reset_mid_wait();
        bit seen = 1'b0;
        rsp_ready = 1'b1;
        cmd_a = 8'd1; cmd_b = 8'd2; cmd_op = 4'd0; cmd_tag = 4'd7; cmd_valid = 1'b1;
        tick();                           // push tag 7
        cmd_a = 8'd3; cmd_b = 8'd4; cmd_tag = 4'd8;
        tick();                           // issue tag 7, push tag 8
        cmd_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        n_cmp++; if ({rsp_valid, cmd_ready, alu_a} !== {1'b0, 1'b0, 8'd0}) begin n_err++; $display("FAIL mid_rst_async: got valid %0b ready %0b alu_a %0d required 0/0/0", rsp_valid, cmd_ready, alu_a); end
        tick(); tick();
        reset_n = 1'b1;
        tick();
        n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL mid_rst_ready: got %0b required 1", cmd_ready); end
        repeat (10) begin
            if (rsp_valid) seen = 1'b1;
            tick();
        end
        n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL mid_rst_no_rsp: got rsp_valid seen %0b required 0", seen); end
        n_cmp++; if (alu_a !== 8'd0) begin n_err++; $display("FAIL mid_rst_fifo_empty: got alu_a %0d required 0", alu_a); end
        rsp_ready = 1'b0;
        test_single_add();
    endtask

    task automatic test_random();
        exp_t q[$];
        exp_t e;
        int   sent = 0;
        int   got  = 0;
        int   cyc  = 0;
        bit   hold = 1'b0;
        bit   acc;
        logic [13:0] prev;
        cmd_valid = 1'b0;
        while ((sent < NRAND || got < sent) && cyc < 4000) begin
            if (!cmd_valid && sent < NRAND && $urandom_range(3) != 0) begin
                cmd_a   = 8'($urandom);
                cmd_b   = ($urandom_range(3) == 0) ? 8'd0 : 8'($urandom);
                cmd_op  = ($urandom_range(4) == 0) ? 4'($urandom_range(15, 4)) : 4'($urandom_range(3));
                cmd_tag = 4'(sent);
                cmd_valid = 1'b1;
            end
            rsp_ready = ($urandom_range(2) != 0);
            if (hold) begin
                n_cmp++;
                if (rsp_valid !== 1'b1 || {rsp_result, rsp_carry, rsp_tag, rsp_err} !== prev) begin
                    n_err++; $display("FAIL rnd_stable: got valid %0b payload %0h required 1/%0h", rsp_valid, {rsp_result, rsp_carry, rsp_tag, rsp_err}, prev);
                end
            end
            hold = rsp_valid && !rsp_ready;
            prev = {rsp_result, rsp_carry, rsp_tag, rsp_err};
            if (rsp_valid && rsp_ready) begin
                n_cmp++;
                if (q.size() == 0) begin n_err++; $display("FAIL rnd_extra_rsp: got tag %0d required none", rsp_tag); end
                else begin
                    e = q.pop_front();
                    if ({rsp_result, rsp_carry, rsp_tag, rsp_err} !== {e.r, e.c, e.t, e.e}) begin
                        n_err++; $display("FAIL rnd_rsp_%0d: got %0h/%0b/%0d/%0b required %0h/%0b/%0d/%0b", got, rsp_result, rsp_carry, rsp_tag, rsp_err, e.r, e.c, e.t, e.e);
                    end
                end
                got++;
            end
            acc = cmd_valid && cmd_ready;
            if (acc) q.push_back(ref_rsp(cmd_a, cmd_b, cmd_op, cmd_tag));
            tick(); cyc++;
            if (acc) begin cmd_valid = 1'b0; sent++; end
        end
        rsp_ready = 1'b0;
        n_cmp++; if (got != NRAND) begin n_err++; $display("FAIL rnd_count: got %0d responses required %0d", got, NRAND); end
    endtask

    initial begin
        reset_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_a = '0; cmd_b = '0; cmd_op = '0; cmd_tag = '0;
        test_reset();
        test_single_add();
        test_back_pressure();
        test_arith();
        test_div_zero();
        test_reset_mid_wait();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
